// File: rtl/instr_mem_loader_if.sv
// AXI-Stream instruction input plus AXI4 write channels for instr_mem_loader.
// master is the loader side; slave is the stream source and memory side.
interface instr_mem_loader_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32
);
   logic [DATA_WIDTH-1:0]   s_axis_tdata;
   logic                    s_axis_tvalid;
   logic                    s_axis_tready;
   logic                    s_axis_tlast;
   logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
   logic [7:0]              m_axi_awlen;
   logic [2:0]              m_axi_awsize;
   logic [1:0]              m_axi_awburst;
   logic                    m_axi_awvalid;
   logic                    m_axi_awready;
   logic [DATA_WIDTH-1:0]   m_axi_wdata;
   logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
   logic                    m_axi_wlast;
   logic                    m_axi_wvalid;
   logic                    m_axi_wready;
   logic [1:0]              m_axi_bresp;
   logic                    m_axi_bvalid;
   logic                    m_axi_bready;

   modport master (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      output s_axis_tready,
      output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bresp, m_axi_bvalid,
      output m_axi_bready
   );

   modport slave (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      input  s_axis_tready,
      input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready
   );
endinterface

// File: rtl/instr_mem_loader.sv
// Streams a tlast-delimited packet of instruction words into AXI4 memory as
// INCR bursts from a programmable base, never crossing a 4 KB page.
module instr_mem_loader #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int BURST_LEN  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [CNT_WIDTH-1:0]  word_count,
   instr_mem_loader_if.master    bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LSB   = $clog2(BYTES);
   localparam int PW    = $clog2(BURST_LEN + 1);
   localparam int IW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   typedef enum logic [2:0] {IDLE, FILL, AW, W, B} state_t;
   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] buffer [BURST_LEN];
   logic [PW-1:0]         fcnt, rptr, limit;
   logic [ADDR_WIDTH-1:0] addr;
   logic [12:0]           room, room_words;
   logic                  last_seen;
   logic                  tready, awvalid, wvalid, wlast, bready;
   logic                  s_hs, launch;

   // Beats that still fit before the next 4 KB page, capped at the burst length.
   assign room       = 13'd4096 - {1'b0, addr[11:0]};
   assign room_words = room >> LSB;
   assign limit      = (room_words >= 13'(BURST_LEN)) ? PW'(BURST_LEN) : PW'(room_words);

   assign s_hs   = bus.s_axis_tvalid && tready;
   assign launch = start && !done;

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tready    = 1'b0;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      wlast     = 1'b0;
      bready    = 1'b0;
      case (state)
         IDLE: if (launch) state_nxt = FILL;
         FILL: begin
            tready = (fcnt < limit);
            if (s_hs && (bus.s_axis_tlast || (fcnt + PW'(1) == limit))) state_nxt = AW;
         end
         AW: begin
            awvalid = 1'b1;
            if (bus.m_axi_awready) state_nxt = W;
         end
         W: begin
            wvalid = 1'b1;
            wlast  = (rptr == fcnt - PW'(1));
            if (bus.m_axi_wready && wlast) state_nxt = B;
         end
         B: begin
            bready = 1'b1;
            if (bus.m_axi_bvalid) state_nxt = last_seen ? IDLE : FILL;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         addr       <= '0;
         fcnt       <= '0;
         rptr       <= '0;
         last_seen  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (launch) begin
               addr       <= base_addr & ~ADDR_WIDTH'(BYTES - 1);
               fcnt       <= '0;
               last_seen  <= 1'b0;
               error      <= 1'b0;
               word_count <= '0;
               busy       <= 1'b1;
            end
            FILL: if (s_hs) begin
               fcnt <= fcnt + PW'(1);
               if (bus.s_axis_tlast) last_seen <= 1'b1;
            end
            AW: rptr <= '0;
            W: if (bus.m_axi_wready) begin
               rptr       <= rptr + PW'(1);
               word_count <= word_count + CNT_WIDTH'(1);
            end
            B: if (bus.m_axi_bvalid) begin
               if (bus.m_axi_bresp != 2'b00) error <= 1'b1;
               addr <= addr + (ADDR_WIDTH'(fcnt) << LSB);
               fcnt <= '0;
               if (last_seen) begin
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  last_seen <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Staging buffer carries no reset; fcnt alone says what is valid.
   always_ff @(posedge ap_clk) begin
      if (s_hs) buffer[fcnt[IW-1:0]] <= bus.s_axis_tdata;
   end

   assign bus.s_axis_tready = tready;
   assign bus.m_axi_awaddr  = awvalid ? addr : '0;
   assign bus.m_axi_awlen   = awvalid ? 8'(fcnt - PW'(1)) : 8'd0;
   assign bus.m_axi_awsize  = 3'(LSB);
   assign bus.m_axi_awburst = 2'b01;
   assign bus.m_axi_awvalid = awvalid;
   assign bus.m_axi_wdata   = wvalid ? buffer[rptr[IW-1:0]] : '0;
   assign bus.m_axi_wstrb   = '1;
   assign bus.m_axi_wlast   = wlast;
   assign bus.m_axi_wvalid  = wvalid;
   assign bus.m_axi_bready  = bready;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: stream source, stalling AXI memory,
// and a page-splitting burst model that predicts addresses, lengths and image.
module tb_instr_mem_loader;
   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        start  = 1'b0;
   logic [31:0] base_addr = '0;
   logic        busy, done, error;
   logic [15:0] word_count;

   instr_mem_loader_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus ();

   instr_mem_loader #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .BURST_LEN(16), .CNT_WIDTH(16)) dut (
      .ap_clk     (ap_clk),
      .ap_rst     (ap_rst),
      .start      (start),
      .base_addr  (base_addr),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .word_count (word_count),
      .bus        (bus)
   );

   always #5 ap_clk = ~ap_clk;

   int          n_chk, n_pass;
   logic [63:0] s_q[$];
   logic [63:0] mem [logic [31:0]];
   logic [39:0] bursts[$];
   int          stall, err_idx, b_cnt, pending_b, done_cnt, beat;
   logic        aw_open, aw_stall, w_stall, t_acc, b_acc;
   logic [31:0] cur_addr, aw_addr_p;
   logic [7:0]  cur_len, aw_len_p;
   logic [63:0] w_data_p;
   logic        w_last_p;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
   endtask

   // Stream source and AXI memory: sample at negedge, drive 1 after posedge.
   initial begin
      forever begin
         @(negedge ap_clk);
         if (ap_rst) begin
            s_q.delete();
            pending_b = 0; beat = 0;
            aw_open = 0; aw_stall = 0; w_stall = 0;
            bus.s_axis_tvalid = 0; bus.m_axi_bvalid = 0; bus.m_axi_bresp = 0;
            bus.m_axi_awready = 0; bus.m_axi_wready = 0;
         end else begin
            t_acc = 0; b_acc = 0;
            if (done) done_cnt++;
            if (aw_stall) begin
               chk("aw_hold_valid", bus.m_axi_awvalid, 1);
               chk("aw_hold_addr", bus.m_axi_awaddr, aw_addr_p);
               chk("aw_hold_len", bus.m_axi_awlen, aw_len_p);
            end
            aw_stall = bus.m_axi_awvalid && !bus.m_axi_awready;
            aw_addr_p = bus.m_axi_awaddr; aw_len_p = bus.m_axi_awlen;
            if (w_stall) begin
               chk("w_hold_valid", bus.m_axi_wvalid, 1);
               chk("w_hold_data", bus.m_axi_wdata, w_data_p);
               chk("w_hold_last", bus.m_axi_wlast, w_last_p);
            end
            w_stall = bus.m_axi_wvalid && !bus.m_axi_wready;
            w_data_p = bus.m_axi_wdata; w_last_p = bus.m_axi_wlast;
            if (bus.s_axis_tvalid && bus.s_axis_tready) begin
               s_q.delete(0);
               t_acc = 1;
            end
            if (bus.m_axi_wvalid && bus.m_axi_wready) begin
               chk("w_after_aw", aw_open, 1);
               chk("wlast", bus.m_axi_wlast, beat == int'(cur_len));
               mem[cur_addr + 32'(beat * 8)] = bus.m_axi_wdata;
               beat++;
               if (bus.m_axi_wlast) begin aw_open = 0; pending_b++; end
            end
            if (bus.m_axi_awvalid && bus.m_axi_awready) begin
               chk("aw_one_outstanding", aw_open || (pending_b > 0), 0);
               chk("aw_no_4k_cross", int'(bus.m_axi_awaddr[11:0]) + (int'(bus.m_axi_awlen) + 1) * 8 <= 4096, 1);
               bursts.push_back({bus.m_axi_awaddr, bus.m_axi_awlen});
               cur_addr = bus.m_axi_awaddr; cur_len = bus.m_axi_awlen;
               beat = 0; aw_open = 1;
            end
            if (bus.m_axi_bvalid && bus.m_axi_bready) begin
               b_cnt++; pending_b--; b_acc = 1;
            end
            @(posedge ap_clk); #1;
            bus.m_axi_awready = int'($urandom_range(99)) >= stall;
            bus.m_axi_wready  = int'($urandom_range(99)) >= stall;
            if (!(bus.s_axis_tvalid && !t_acc)) begin
               bus.s_axis_tvalid = 0;
               if (s_q.size() > 0 && int'($urandom_range(99)) >= stall) begin
                  bus.s_axis_tvalid = 1;
                  bus.s_axis_tdata  = s_q[0];
                  bus.s_axis_tlast  = (s_q.size() == 1);
               end
            end
            if (!(bus.m_axi_bvalid && !b_acc)) begin
               bus.m_axi_bvalid = 0; bus.m_axi_bresp = 2'b00;
               if (pending_b > 0 && int'($urandom_range(99)) >= stall) begin
                  bus.m_axi_bvalid = 1;
                  bus.m_axi_bresp  = (b_cnt + 1 == err_idx) ? 2'b10 : 2'b00;
               end
            end
         end
      end
   end

   task automatic run_load(input logic [31:0] base, input int n, input int e_idx,
                           input int st, input bit clash);
      logic [63:0] words[$];
      logic [39:0] exp_b[$];
      logic [31:0] a, a0;
      logic [63:0] got_w;
      int          rem, lim, len;
      bit          got;
      mem.delete(); bursts.delete();
      done_cnt = 0; b_cnt = 0; err_idx = e_idx; stall = st;
      for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
      // Expected bursts: fill to page end or 16 beats, whichever is first.
      a0 = base & ~32'h7; a = a0; rem = n;
      while (rem > 0) begin
         lim = (4096 - int'(a[11:0])) / 8;
         if (lim > 16) lim = 16;
         len = (rem < lim) ? rem : lim;
         exp_b.push_back({a, 8'(len - 1)});
         a += 32'(len * 8);
         rem -= len;
      end
      s_q = words;
      @(posedge ap_clk); #1; base_addr = base; start = 1;
      @(posedge ap_clk); #1; start = 0;
      chk("busy_after_start", busy, 1);
      chk("error_cleared", error, 0);
      chk("count_cleared", word_count, 0);
      got = 0;
      for (int c = 0; c < 5000 && !got; c++) begin
         @(negedge ap_clk);
         got = done;
      end
      chk("done_seen", got, 1);
      if (clash) start = 1;
      @(posedge ap_clk); #1; start = 0;
      chk("idle_after_done", busy, 0);
      repeat (3) @(posedge ap_clk);
      #1;
      chk("done_pulses", done_cnt, 1);
      chk("word_count", word_count, 16'(n));
      chk("error", error, (e_idx > 0 && e_idx <= exp_b.size()) ? 1 : 0);
      chk("stream_drained", s_q.size(), 0);
      chk("burst_count", bursts.size(), exp_b.size());
      for (int i = 0; i < exp_b.size() && i < bursts.size(); i++) chk("burst", bursts[i], exp_b[i]);
      for (int i = 0; i < n; i++) begin
         a = a0 + 32'(i * 8);
         got_w = mem.exists(a) ? mem[a] : ~words[i];
         chk("mem", got_w, words[i]);
      end
   endtask

   initial begin
      bit got;
      bus.s_axis_tvalid = 0; bus.s_axis_tdata = '0; bus.s_axis_tlast = 0;
      bus.m_axi_awready = 0; bus.m_axi_wready = 0;
      bus.m_axi_bvalid = 0; bus.m_axi_bresp = 2'b00;
      repeat (3) @(negedge ap_clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_count", word_count, 0);
      chk("rst_tready", bus.s_axis_tready, 0);
      chk("rst_awvalid", bus.m_axi_awvalid, 0);
      chk("rst_awaddr", bus.m_axi_awaddr, 0);
      chk("rst_awlen", bus.m_axi_awlen, 0);
      chk("rst_wvalid", bus.m_axi_wvalid, 0);
      chk("rst_wlast", bus.m_axi_wlast, 0);
      chk("rst_bready", bus.m_axi_bready, 0);
      chk("awsize", bus.m_axi_awsize, 3);
      chk("awburst", bus.m_axi_awburst, 1);
      chk("wstrb", bus.m_axi_wstrb, 8'hFF);
      ap_rst = 0;

      run_load(32'h0000_0000, 3, 0, 0, 1);
      run_load(32'h0000_0100, 40, 0, 0, 0);
      run_load(32'h0000_0FF0, 5, 0, 0, 0);
      run_load(32'h0000_0200, 40, 2, 0, 0);
      run_load(32'h0000_0000, 4, 0, 0, 0);
      run_load(32'h0000_0FC8, 37, 0, 40, 0);
      for (int k = 0; k < 3; k++)
         run_load($urandom & 32'h0000_3FFF, int'($urandom_range(1, 50)), int'($urandom_range(0, 3)), 30, 0);
      run_load(32'hFFFF_FFE0, 6, 0, 20, 0);

      // Reset in the middle of a 16-beat W phase.
      mem.delete(); bursts.delete(); stall = 0; err_idx = 0;
      for (int i = 0; i < 20; i++) s_q.push_back({$urandom, $urandom});
      @(posedge ap_clk); #1; base_addr = '0; start = 1;
      @(posedge ap_clk); #1; start = 0;
      got = 0;
      for (int c = 0; c < 2000 && !got; c++) begin
         @(negedge ap_clk);
         got = aw_open && beat >= 5 && bus.m_axi_wvalid;
      end
      chk("reached_mid_w", got, 1);
      #2 ap_rst = 1;
      #1;
      chk("rst_mid_wvalid", bus.m_axi_wvalid, 0);
      chk("rst_mid_awvalid", bus.m_axi_awvalid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_tready", bus.s_axis_tready, 0);
      chk("rst_mid_done", done, 0);
      repeat (2) @(negedge ap_clk);
      ap_rst = 0;
      run_load(32'h0000_0040, 2, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Upstream feeder for the kernel's AXI4 instruction memories (block-RAM AXI4 slaves, 64-bit data, 32-bit address).
- Accepts a tlast-delimited AXI-Stream of instruction words and writes them sequentially from a programmable base address.
- Writes use AXI4 INCR bursts that never cross a 4 KB boundary.
- Lets a testbench or host preload instruction memory before the kernel leaves reset.

Parameters:
DATA_WIDTH, 64, stream and AXI data width in bits (power of two, >= 32)
ADDR_WIDTH, 32, AXI address width
BURST_LEN, 16, maximum beats per AXI burst (1..256)
CNT_WIDTH, 16, width of the word_count output

Ports:
ap_clk  in  1  clock
ap_rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse that begins a load; ignored while busy
base_addr  in  ADDR_WIDTH  byte address of first word, sampled on start; low log2(DATA_WIDTH/8) bits forced to 0
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after the final B response of the packet
error  out  1  sticky; set on any bresp != OKAY; cleared by start
word_count  out  CNT_WIDTH  W beats completed since start; wraps modulo 2^CNT_WIDTH
s_axis_tdata  in  DATA_WIDTH  instruction word
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
s_axis_tlast  in  1  last word of the load
m_axi_awaddr  out  ADDR_WIDTH  burst start address
m_axi_awlen  out  8  beats minus one
m_axi_awsize  out  3  constant log2(DATA_WIDTH/8)
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid  out  1
m_axi_awready  in  1
m_axi_wdata  out  DATA_WIDTH
m_axi_wstrb  out  DATA_WIDTH/8  constant all ones
m_axi_wlast  out  1
m_axi_wvalid  out  1
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1

Behaviour:
- Reset values: all outputs 0 except the constants awsize, awburst and wstrb. Internal address register, buffer count and FSM state are also cleared.
- Reset during any state returns the FSM to IDLE immediately. The burst in flight is abandoned, all valids drop asynchronously, and no done pulse is issued.
- Buffer: BURST_LEN x DATA_WIDTH register array with write pointer fcnt and read pointer rptr.
- limit = min(BURST_LEN, (4096 - addr[11:0]) / (DATA_WIDTH/8)), computed from the current address register.
- FSM states:
  - IDLE: s_axis_tready = 0. On start: addr <= base_addr aligned, error <= 0, word_count <= 0, busy <= 1, go to FILL.
  - FILL: s_axis_tready = (fcnt < limit). Each tvalid&tready handshake stores tdata at fcnt and increments fcnt; a stored tlast sets last_seen. Go to AW the cycle after fcnt reaches limit or after a tlast handshake.
  - AW: awvalid = 1, awaddr = addr, awlen = fcnt-1. Hold all AW signals stable until awready. Then go to W with rptr = 0.
  - W: wvalid = 1, wdata = buf[rptr], wlast = (rptr == fcnt-1). Advance rptr and word_count on each wready. Go to B after the wlast handshake.
  - B: bready = 1. On bvalid: set error if bresp != 2'b00; addr <= addr + fcnt*(DATA_WIDTH/8); fcnt <= 0. Then go to IDLE if last_seen (busy <= 0, done = 1 for one cycle, last_seen <= 0), otherwise back to FILL.
- AW and W are strictly sequential; no W beat is issued before the AW handshake. Exactly one outstanding burst at a time.
- Stream is backpressured (tready = 0) in AW, W and B. No word is ever dropped.
- Error response does not abort the load; remaining words are still written.
- A start pulse that coincides with done is ignored.
- Latency: first awvalid is asserted 1 cycle after the limit-th or tlast handshake.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

Test Plan:
- start, base 0x0, 3-word packet A,B,C (tlast on C) -> one burst awaddr=0x0, awlen=2; W beats A,B,C with wlast on C; done after B; word_count=3; error=0.
- base 0x100, 40 words -> bursts at 0x100/len15, 0x180/len15, 0x200/len7; word_count=40; exactly one done pulse.
- base 0x0FF0, 5 words -> burst 0x0FF0/len1, then 0x1000/len2; no burst crosses 0x1000.
- Second burst answered with bresp=2'b10 -> error=1 after that B; remaining bursts still issued; done asserts; next start clears error.
- Random awready/wready/bvalid stalls and tvalid gaps on a 37-word packet -> memory image identical to the stimulus; AW/W signals stable while valid and not ready.
- ap_rst asserted mid-W of a 16-beat burst -> wvalid/awvalid/busy/s_axis_tready at 0 in the same cycle; a subsequent start with 2 words completes normally with word_count=2.
